mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single TinyRISC-V memory port between two masters: instruction fetch (m0, IFU) and load/store unit (m1, LSU).
- Allows one outstanding transaction at a time.
- Selects a winner, forwards its request to the slave and tracks the owner until the response returns.
- Routes the read data or write acknowledge back to the owner.
- Sits between the core front end/LSU and the memory or peripheral bus.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  IFU request
m0_addr  in  AW  IFU address (read only)
m0_gnt  out  1  IFU request accepted this cycle
m0_rvalid  out  1  IFU read data valid (registered)
m0_rdata  out  DW  IFU read data (registered)
m1_req  in  1  LSU request
m1_we  in  1  LSU write enable
m1_addr  in  AW  LSU address
m1_wdata  in  DW  LSU write data
m1_wstrb  in  DW/8  LSU byte strobes
m1_gnt  out  1  LSU request accepted this cycle
m1_rvalid  out  1  LSU read data valid / write ack (registered)
m1_rdata  out  DW  LSU read data (registered)
s_req  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_wstrb  out  DW/8  slave byte strobes
s_gnt  in  1  slave accepts request
s_rvalid  in  1  slave response valid (every request gets exactly one)
s_rdata  in  DW  slave read data

Behaviour:
Clock and reset:
- Single clock `clk`.
- `rst_n` is asynchronous, active-low.
- Reset values:
  - state=IDLE, owner=0.
  - All rvalid outputs 0, all rdata outputs 0.
  - s_req 0; s_* data outputs 0.
  - Optional-feature priority pointer last=0.

State IDLE:
- Winner chosen combinationally from m0_req/m1_req.
- Default policy: fixed priority, LSU (m1) beats IFU (m0).
- s_req = m0_req | m1_req; s_we/s_addr/s_wdata/s_wstrb are muxed from the winner.
- For m0: s_we=0, s_wstrb=0, s_wdata=0.
- If s_req & s_gnt:
  - Winner's gnt=1 in the same cycle (combinational); the loser's gnt stays 0.
  - owner<=winner; go to WAIT.
- Without s_gnt: remain in IDLE. Masters hold req and payload stable until gnt; the arbiter may switch winner if a higher-priority req appears.

State WAIT:
- s_req=0, both gnt=0; new requests stall.
- When s_rvalid=1:
  - owner's rvalid<=1 and rdata<=s_rdata on the next edge.
  - go to IDLE.
- Write responses set rvalid with rdata=s_rdata (don't-care to LSU).

Latency and throughput:
- Minimum 2 cycles from gnt to master rvalid: slave responds the cycle after gnt, plus 1 register stage.
- Peak 1 transaction per 2 cycles (IDLE accept, WAIT response); no same-cycle response-plus-new-grant.

Boundary conditions:
- m*_rvalid is a single-cycle pulse; the non-owner's rvalid is never asserted.
- rdata holds its last value when rvalid=0.
- s_rvalid while in IDLE (stray or post-reset) is ignored and not forwarded.
- Simultaneous m0_req & m1_req: m1 wins by default.
- Reset mid-WAIT abandons the transaction; no rvalid is issued to either master.
- The slave must tolerate this; a late s_rvalid falls under the IDLE-ignore rule.

Optional Feature:
Macro: MEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - 1-bit register `last` records the most recent granted master, updated on each gnt.
  - On simultaneous requests, the master ≠ last wins.
  - A single requester always wins.
- Undefined: fixed LSU priority; `last` is not instantiated. IFU can be starved by continuous LSU requests. This is accepted because the LSU never issues back-to-back requests in the pipeline.

Decomposition:
- Shared package `tinyrv_bus_pkg`:
  - AW/DW defaults.
  - Master index constants MST_IFU=0, MST_LSU=1.
  - State encoding ARB_IDLE=1'b0, ARB_WAIT=1'b1.
- Sub-module `mem_arb_pick` (combinational winner select: req[1:0] plus optional last → one-hot grant vector). It isolates the MEM_ARB_RR_EN policy.
- FSM, muxing and response routing stay in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n=0 with m0_req=1; release.
   - Required: all outputs 0 during reset; m0_gnt=1 on the first cycle s_gnt=1, s_addr=m0_addr=32'h0000_0100.
2. IFU read:
   - Stimulus: m0 reads 32'h0000_0040; slave responds s_rdata=32'hDEAD_BEEF one cycle after gnt.
   - Required: m0_rvalid=1 for exactly one cycle with m0_rdata=32'hDEAD_BEEF, 2 cycles after m0_gnt; m1_rvalid stays 0.
3. Simultaneous requests:
   - Stimulus: m0_req and m1_req both raised, m1 a write (addr 32'h0000_2000, wdata 32'h1234_5678, wstrb 4'hF).
   - Required, default build: m1_gnt first, s_we=1, s_wstrb=4'hF; m0 granted only after m1_rvalid.
   - Required, MEM_ARB_RR_EN with last=LSU: m0 granted first.
4. Slave backpressure:
   - Stimulus: s_gnt=0 for 5 cycles with m1_req held.
   - Required: no gnt, state stays IDLE, s_addr is stable; grant occurs on the cycle s_gnt=1.
5. Stall and stray response:
   - Stimulus: m0_req held during WAIT.
   - Required: m0_gnt stays 0 until after the response.
   - Stimulus: s_rvalid pulsed in IDLE.
   - Required: no m*_rvalid.
6. Reset mid-operation:
   - Stimulus: assert rst_n=0 in WAIT, then deliver s_rvalid after release.
   - Required: no rvalid to either master; the next request is granted normally.

Source files
------------

// File: rtl/tinyrv_bus_pkg.sv
// Shared TinyRISC-V memory-bus definitions: default widths, master indices
// and the arbiter state encoding.
package tinyrv_bus_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two master ports (IFU m0, LSU m1) and the single slave port.
// modport master: the arbiter's view; modport slave: the surrounding masters and memory.
interface mem_bus_arbiter_if #(
  parameter int AW = tinyrv_bus_pkg::AW_DEF,
  parameter int DW = tinyrv_bus_pkg::DW_DEF
);
  // Handshake: a requester holds req and its payload stable until it sees gnt
  // high in the same cycle; each accepted request gets exactly one rvalid later.
  logic            m0_req;
  logic [AW-1:0]   m0_addr;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [DW-1:0]   m0_rdata;

  logic            m1_req;
  logic            m1_we;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [DW-1:0]   m1_rdata;

  logic            s_req;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_gnt;
  logic            s_rvalid;
  logic [DW-1:0]   s_rdata;

  modport master (
    input  m0_req, m0_addr,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_req, s_we, s_addr, s_wdata, s_wstrb,
    input  s_gnt, s_rvalid, s_rdata
  );

  modport slave (
    output m0_req, m0_addr,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_req, s_we, s_addr, s_wdata, s_wstrb,
    output s_gnt, s_rvalid, s_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter. Default: LSU beats IFU.
// With MEM_ARB_RR_EN defined, simultaneous requests go to the master that was not granted last.
module mem_arb_pick
  import tinyrv_bus_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
`ifdef MEM_ARB_RR_EN
    if (&req) begin
      gnt = (last == MST_LSU) ? 2'b01 : 2'b10;
    end
`else
    if (req[MST_LSU]) begin
      gnt = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-outstanding arbiter for the TinyRISC-V memory port.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_bus_arbiter
  import tinyrv_bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_bus_arbiter_if.master        bus,
  output arb_state_e               dbg_state
);

  arb_state_e      state, state_nxt;
  logic            owner;
  logic [1:0]      req, pick;
  logic            accept;
  logic            s_req, s_we, m0_gnt, m1_gnt;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0]   m0_rdata_q, m1_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic            last;
`endif

  // Requests are masked during reset so every combinational output reads 0.
  assign req = {bus.m1_req, bus.m0_req} & {2{rst_n}};

  mem_arb_pick u_pick (
    .req  (req),
`ifdef MEM_ARB_RR_EN
    .last (last),
`endif
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    s_req     = 1'b0;
    s_we      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    case (state)
      ARB_IDLE: begin
        s_req = |req;
        if (pick[MST_LSU]) begin
          s_we    = bus.m1_we;
          s_addr  = bus.m1_addr;
          s_wdata = bus.m1_wdata;
          s_wstrb = bus.m1_wstrb;
        end else if (pick[MST_IFU]) begin
          s_addr  = bus.m0_addr;
        end
        if (s_req && bus.s_gnt) begin
          accept    = 1'b1;
          m0_gnt    = pick[MST_IFU];
          m1_gnt    = pick[MST_LSU];
          state_nxt = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.s_rvalid) state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Responses only count in WAIT; a stray s_rvalid in IDLE falls through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= MST_IFU;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last        <= MST_IFU;
`endif
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      if (accept) begin
        owner <= pick[MST_LSU];
`ifdef MEM_ARB_RR_EN
        last  <= pick[MST_LSU];
`endif
      end
      if (state == ARB_WAIT && bus.s_rvalid) begin
        if (owner == MST_LSU) begin
          m1_rvalid_q <= 1'b1;
          m1_rdata_q  <= bus.s_rdata;
        end else begin
          m0_rvalid_q <= 1'b1;
          m0_rdata_q  <= bus.s_rdata;
        end
      end
    end
  end

  assign bus.s_req     = s_req;
  assign bus.s_we      = s_we;
  assign bus.s_addr    = s_addr;
  assign bus.s_wdata   = s_wdata;
  assign bus.s_wstrb   = s_wstrb;
  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
  import tinyrv_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_e dbg_state;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] exp_q[$];          // {owner, rdata} responses due next cycle
  logic        busy     = 1'b0;   // one transaction outstanding at the slave
  logic        owner_m  = 1'b0;   // 1 = LSU
  logic [31:0] exp_rd0  = '0;
  logic [31:0] exp_rd1  = '0;
`ifdef MEM_ARB_RR_EN
  logic        last_m   = 1'b0;
`endif

  // ---------------- driver state ----------------
  logic        m0_done = 0, m1_done = 0;
  logic        slave_pend = 0;
  int          slave_dly = 0;
  int          max_dly = 0;
  logic        want_m0 = 0, want_m1 = 0;
  logic [31:0] want_m0_addr = '0, want_m1_addr = '0, want_m1_wdata = '0;
  logic        want_m1_we = 0;
  logic [3:0]  want_m1_wstrb = '0;
  logic        force_rd = 0;
  logic [31:0] force_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Winner per the arbitration policy: 1 = LSU, 0 = IFU.
  function automatic logic model_pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
      return ~last_m;
`else
      return 1'b1;
`endif
    end
    return r1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Checks the DUT against the model for the current cycle, then advances the
  // model across the coming clock edge.
  task automatic eval();
    logic [32:0] e;
    logic        w, exp_sreq, exp_g, exp_rv0, exp_rv1;
    #1;
    if (!rst_n) begin
      check("rst_s_req",     bus.s_req,     0);
      check("rst_s_addr",    bus.s_addr,    0);
      check("rst_s_we",      bus.s_we,      0);
      check("rst_s_wdata",   bus.s_wdata,   0);
      check("rst_s_wstrb",   bus.s_wstrb,   0);
      check("rst_m0_gnt",    bus.m0_gnt,    0);
      check("rst_m1_gnt",    bus.m1_gnt,    0);
      check("rst_m0_rvalid", bus.m0_rvalid, 0);
      check("rst_m1_rvalid", bus.m1_rvalid, 0);
      check("rst_m0_rdata",  bus.m0_rdata,  0);
      check("rst_m1_rdata",  bus.m1_rdata,  0);
      check("rst_state",     dbg_state,     ARB_IDLE);
      busy = 0; exp_rd0 = '0; exp_rd1 = '0; exp_q.delete();
`ifdef MEM_ARB_RR_EN
      last_m = 0;
`endif
      return;
    end
    exp_rv0 = 0; exp_rv1 = 0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e[32]) begin exp_rv1 = 1; exp_rd1 = e[31:0]; end
      else       begin exp_rv0 = 1; exp_rd0 = e[31:0]; end
    end
    check("m0_rvalid", bus.m0_rvalid, exp_rv0);
    check("m1_rvalid", bus.m1_rvalid, exp_rv1);
    check("m0_rdata",  bus.m0_rdata,  exp_rd0);
    check("m1_rdata",  bus.m1_rdata,  exp_rd1);

    w        = model_pick(bus.m0_req, bus.m1_req);
    exp_sreq = !busy && (bus.m0_req || bus.m1_req);
    exp_g    = exp_sreq && bus.s_gnt;
    check("state",  dbg_state,  busy ? ARB_WAIT : ARB_IDLE);
    check("s_req",  bus.s_req,  exp_sreq);
    check("m0_gnt", bus.m0_gnt, exp_g && !w);
    check("m1_gnt", bus.m1_gnt, exp_g && w);
    if (exp_sreq) begin
      check("s_addr",  bus.s_addr,  w ? bus.m1_addr  : bus.m0_addr);
      check("s_we",    bus.s_we,    w ? bus.m1_we    : 1'b0);
      check("s_wdata", bus.s_wdata, w ? bus.m1_wdata : 32'h0);
      check("s_wstrb", bus.s_wstrb, w ? bus.m1_wstrb : 4'h0);
    end

    if (busy && bus.s_rvalid) begin
      exp_q.push_back({owner_m, bus.s_rdata});
      busy = 0;
    end else if (exp_g) begin
      busy = 1; owner_m = w;
`ifdef MEM_ARB_RR_EN
      last_m = w;
`endif
    end
  endtask

  task automatic observe();
    if (bus.m0_gnt) m0_done = 1;
    if (bus.m1_gnt) m1_done = 1;
    if (bus.s_req && bus.s_gnt) begin
      slave_pend = 1;
      slave_dly  = $urandom_range(0, max_dly);
    end
  endtask

  // One clock of traffic: masters hold requests until granted, slave accepts
  // with probability gnt_pct and answers after a random delay.
  task automatic cycle(input int req_pct, input int gnt_pct, input int stray_pct);
    tick();
    if (m0_done) begin bus.m0_req = 0; m0_done = 0; end
    if (m1_done) begin bus.m1_req = 0; m1_done = 0; end
    if (!bus.m0_req) begin
      if (want_m0) begin
        bus.m0_req = 1; bus.m0_addr = want_m0_addr; want_m0 = 0;
      end else if ($urandom_range(0, 99) < req_pct) begin
        bus.m0_req = 1; bus.m0_addr = $urandom();
      end
    end
    if (!bus.m1_req) begin
      if (want_m1) begin
        bus.m1_req = 1; bus.m1_we = want_m1_we; bus.m1_addr = want_m1_addr;
        bus.m1_wdata = want_m1_wdata; bus.m1_wstrb = want_m1_wstrb; want_m1 = 0;
      end else if ($urandom_range(0, 99) < req_pct) begin
        bus.m1_req = 1; bus.m1_we = 1'($urandom_range(0, 1)); bus.m1_addr = $urandom();
        bus.m1_wdata = $urandom(); bus.m1_wstrb = 4'($urandom_range(0, 15));
      end
    end
    bus.s_gnt    = ($urandom_range(0, 99) < gnt_pct);
    bus.s_rvalid = 0;
    if (slave_pend) begin
      if (slave_dly == 0) begin
        bus.s_rvalid = 1;
        bus.s_rdata  = force_rd ? force_val : $urandom();
        force_rd = 0; slave_pend = 0;
      end else begin
        slave_dly--;
      end
    end else if ($urandom_range(0, 99) < stray_pct) begin
      bus.s_rvalid = 1;
      bus.s_rdata  = $urandom();
    end
    eval();
    observe();
  endtask

  task automatic set_m1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
    want_m1 = 1; want_m1_we = we; want_m1_addr = addr;
    want_m1_wdata = wdata; want_m1_wstrb = wstrb;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    bus.m0_req = 1; bus.m0_addr = 32'h0000_0100;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.s_gnt = 1; bus.s_rvalid = 0; bus.s_rdata = '0;

    // Reset with IFU requesting, then first grant on release.
    repeat (3) begin tick(); eval(); end
    tick(); rst_n = 1; eval();
    check("t1_first_gnt", bus.m0_gnt, 1);
    check("t1_s_addr", bus.s_addr, 32'h0000_0100);
    observe();
    repeat (3) cycle(0, 100, 0);

    // IFU read, slave answers one cycle after grant.
    want_m0 = 1; want_m0_addr = 32'h0000_0040; force_rd = 1; force_val = 32'hDEAD_BEEF;
    cycle(0, 100, 0); check("t2_gnt", bus.m0_gnt, 1);
    cycle(0, 100, 0); check("t2_early", bus.m0_rvalid, 0);
    cycle(0, 100, 0);
    check("t2_rvalid", bus.m0_rvalid, 1);
    check("t2_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    check("t2_m1_quiet", bus.m1_rvalid, 0);
    cycle(0, 100, 0); check("t2_pulse", bus.m0_rvalid, 0);

    // LSU read so the last grant went to LSU, then simultaneous requests.
    set_m1(0, 32'h0000_0300, 32'h0, 4'h0);
    repeat (4) cycle(0, 100, 0);
    want_m0 = 1; want_m0_addr = 32'h0000_0080;
    set_m1(1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    cycle(0, 100, 0);
`ifdef MEM_ARB_RR_EN
    check("t3_rr_m0_first", bus.m0_gnt, 1);
`else
    check("t3_m1_first", bus.m1_gnt, 1);
    check("t3_s_we", bus.s_we, 1);
    check("t3_s_wstrb", bus.s_wstrb, 4'hF);
`endif
    repeat (8) cycle(0, 100, 0);

    // Slave backpressure for 5 cycles.
    set_m1(0, 32'h0000_0500, 32'h0, 4'h0);
    repeat (5) begin
      cycle(0, 0, 0);
      check("t4_no_gnt", bus.m1_gnt, 0);
      check("t4_addr", bus.s_addr, 32'h0000_0500);
    end
    cycle(0, 100, 0); check("t4_gnt", bus.m1_gnt, 1);
    repeat (4) cycle(0, 100, 0);

    // Requests held through WAIT, then stray responses in IDLE.
    max_dly = 2;
    repeat (12) cycle(100, 100, 0);
    repeat (16) cycle(0, 100, 0);
    repeat (4) cycle(0, 0, 100);
    cycle(0, 0, 0);
    check("t5_stray_m0", bus.m0_rvalid, 0);
    check("t5_stray_m1", bus.m1_rvalid, 0);

    // Reset in WAIT, late slave response afterwards.
    max_dly = 0;
    set_m1(0, 32'h0000_0600, 32'h0, 4'h0);
    cycle(0, 100, 0); check("t6_gnt", bus.m1_gnt, 1);
    tick(); rst_n = 0; bus.m0_req = 0; bus.m1_req = 0; bus.s_rvalid = 0; eval();
    m0_done = 0; m1_done = 0; slave_pend = 0;
    tick(); rst_n = 1; eval();
    tick(); bus.s_rvalid = 1; bus.s_rdata = 32'hBAD0_0BAD; eval();
    tick(); bus.s_rvalid = 0; eval();
    check("t6_no_m0_rvalid", bus.m0_rvalid, 0);
    check("t6_no_m1_rvalid", bus.m1_rvalid, 0);
    want_m0 = 1; want_m0_addr = 32'h0000_0700;
    cycle(0, 100, 0); check("t6_regrant", bus.m0_gnt, 1);
    repeat (3) cycle(0, 100, 0);

    // Random traffic.
    max_dly = 2;
    repeat (400) cycle(40, 70, 5);
    repeat (16) cycle(0, 100, 0);
    check("end_idle", dbg_state, ARB_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
